cyt_sq_credit_gate: RTL and testbench

Flow-control stage between the ACCL command issuers and the Coyote send-queue and completion-queue descriptor interfaces, on one direction (rd or wr); one instance per direction. It forwards send-queue descriptors to Coyote only while the count of outstanding (issued, not yet completed) commands is below a credit limit. It forwards completion-queue entries back to ACCL and decrements that count as each one arrives. Both paths are single-register slices. The block also exposes occupancy, a stall counter and a sticky underflow error for debug readback over AXI4-Lite.

---
 rtl/cyt_sq_credit_gate.sv | 148 ++++++++++++++
 tb/tb_cyt_sq_credit_gate.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cyt_sq_credit_gate.sv
// Credit-gated send-queue / completion-queue register slices for one ACCL<->Coyote direction.
// Credits are taken when a descriptor enters the SQ slice and returned when a completion enters the CQ slice.
module cyt_sq_credit_gate #(
    parameter int SQ_BITS         = 128,
    parameter int CQ_BITS         = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_sq_valid,
    output logic                s_sq_ready,
    input  logic [SQ_BITS-1:0]  s_sq_data,
    output logic                m_sq_valid,
    input  logic                m_sq_ready,
    output logic [SQ_BITS-1:0]  m_sq_data,
    input  logic                s_cq_valid,
    output logic                s_cq_ready,
    input  logic [CQ_BITS-1:0]  s_cq_data,
    output logic                m_cq_valid,
    input  logic                m_cq_ready,
    output logic [CQ_BITS-1:0]  m_cq_data,
    output logic [CNT_BITS-1:0] outstanding,
    output logic [31:0]         stall_cycles,
    output logic                err_underflow,
    input  logic                clr_err
);

    localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [CNT_BITS-1:0] CNT_ZERO  = CNT_BITS'(0);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [31:0]         STALL_SAT = 32'hFFFF_FFFF;

    logic                m_sq_valid_q, m_sq_valid_d;
    logic [SQ_BITS-1:0]  m_sq_data_q, m_sq_data_d;
    logic                m_cq_valid_q, m_cq_valid_d;
    logic [CQ_BITS-1:0]  m_cq_data_q, m_cq_data_d;
    logic [CNT_BITS-1:0] outstanding_q, outstanding_d;
    logic [31:0]         stall_q, stall_d;
    logic                err_q, err_d;

    logic credit_ok_s;
    logic sq_acc_s;
    logic sq_out_s;
    logic cq_acc_s;
    logic cq_out_s;
    logic underflow_s;

    assign credit_ok_s = (outstanding_q < CNT_MAX);
    assign s_sq_ready  = credit_ok_s && (!m_sq_valid_q || m_sq_ready);
    assign s_cq_ready  = !m_cq_valid_q || m_cq_ready;
    assign sq_acc_s    = s_sq_valid && s_sq_ready;
    assign sq_out_s    = m_sq_valid_q && m_sq_ready;
    assign cq_acc_s    = s_cq_valid && s_cq_ready;
    assign cq_out_s    = m_cq_valid_q && m_cq_ready;

    // SQ and CQ slice next-state
    always_comb begin
        m_sq_valid_d = m_sq_valid_q;
        m_sq_data_d  = m_sq_data_q;
        m_cq_valid_d = m_cq_valid_q;
        m_cq_data_d  = m_cq_data_q;
        if (sq_acc_s) begin
            m_sq_valid_d = 1'b1;
            m_sq_data_d  = s_sq_data;
        end else if (sq_out_s) begin
            m_sq_valid_d = 1'b0;
        end else begin
            m_sq_valid_d = m_sq_valid_q;
        end
        if (cq_acc_s) begin
            m_cq_valid_d = 1'b1;
            m_cq_data_d  = s_cq_data;
        end else if (cq_out_s) begin
            m_cq_valid_d = 1'b0;
        end else begin
            m_cq_valid_d = m_cq_valid_q;
        end
    end

    // Credit counter; a completion with nothing outstanding and no matching issue is an underflow
    always_comb begin
        outstanding_d = outstanding_q;
        underflow_s   = 1'b0;
        case ({sq_acc_s, cq_acc_s})
            2'b10: outstanding_d = outstanding_q + CNT_ONE;
            2'b01: begin
                if (outstanding_q != CNT_ZERO) begin
                    outstanding_d = outstanding_q - CNT_ONE;
                end else begin
                    underflow_s = 1'b1;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Debug counters; clear wins over a same-cycle set
    always_comb begin
        stall_d = stall_q;
        err_d   = err_q;
        if (clr_err) begin
            stall_d = 32'h0000_0000;
            err_d   = 1'b0;
        end else begin
            if (s_sq_valid && !credit_ok_s && (stall_q != STALL_SAT)) begin
                stall_d = stall_q + 32'h0000_0001;
            end else begin
                stall_d = stall_q;
            end
            if (underflow_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_sq_valid_q  <= 1'b0;
            m_sq_data_q   <= '0;
            m_cq_valid_q  <= 1'b0;
            m_cq_data_q   <= '0;
            outstanding_q <= '0;
            stall_q       <= 32'h0000_0000;
            err_q         <= 1'b0;
        end else begin
            m_sq_valid_q  <= m_sq_valid_d;
            m_sq_data_q   <= m_sq_data_d;
            m_cq_valid_q  <= m_cq_valid_d;
            m_cq_data_q   <= m_cq_data_d;
            outstanding_q <= outstanding_d;
            stall_q       <= stall_d;
            err_q         <= err_d;
        end
    end

    assign m_sq_valid    = m_sq_valid_q;
    assign m_sq_data     = m_sq_data_q;
    assign m_cq_valid    = m_cq_valid_q;
    assign m_cq_data     = m_cq_data_q;
    assign outstanding   = outstanding_q;
    assign stall_cycles  = stall_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_cyt_sq_credit_gate.sv
// Randomized bench for cyt_sq_credit_gate against a queue-based transaction model.
module tb_cyt_sq_credit_gate;

    localparam int SQB   = 128;
    localparam int CQB   = 32;
    localparam int MAXO  = 4;
    localparam int CNTW  = $clog2(MAXO + 1);
    localparam int NCYC  = 3000;

    logic            aclk = 1'b0;
    logic            areset;
    logic            s_sq_valid, s_sq_ready, m_sq_valid, m_sq_ready;
    logic [SQB-1:0]  s_sq_data, m_sq_data;
    logic            s_cq_valid, s_cq_ready, m_cq_valid, m_cq_ready;
    logic [CQB-1:0]  s_cq_data, m_cq_data;
    logic [CNTW-1:0] outstanding;
    logic [31:0]     stall_cycles;
    logic            err_underflow;
    logic            clr_err;

    int n_checks = 0;
    int n_pass   = 0;

    cyt_sq_credit_gate #(
        .SQ_BITS(SQB), .CQ_BITS(CQB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
        .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
        .s_cq_valid(s_cq_valid), .s_cq_ready(s_cq_ready), .s_cq_data(s_cq_data),
        .m_cq_valid(m_cq_valid), .m_cq_ready(m_cq_ready), .m_cq_data(m_cq_data),
        .outstanding(outstanding), .stall_cycles(stall_cycles),
        .err_underflow(err_underflow), .clr_err(clr_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: each slice is a queue holding at most one item in flight
    logic [SQB-1:0] sq_q[$];
    logic [CQB-1:0] cq_q[$];
    logic [SQB-1:0] sq_last;
    logic [CQB-1:0] cq_last;
    int             mdl_cnt;
    longint         mdl_stall;
    bit             mdl_err;

    function automatic logic [SQB-1:0] rnd_sq();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic mdl_reset();
        sq_q.delete();
        cq_q.delete();
        sq_last   = '0;
        cq_last   = '0;
        mdl_cnt   = 0;
        mdl_stall = 0;
        mdl_err   = 1'b0;
    endtask

    initial begin
        bit exp_sq_rdy, exp_cq_rdy;
        bit inc, dec, sq_out, cq_out;
        int cq_pct, mr_pct;

        areset = 1'b1; clr_err = 1'b0;
        s_sq_valid = 1'b0; s_sq_data = '0; m_sq_ready = 1'b0;
        s_cq_valid = 1'b0; s_cq_data = '0; m_cq_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        mdl_reset();

        for (int c = 0; c < NCYC; c++) begin
            @(negedge aclk);
            exp_sq_rdy = (mdl_cnt < MAXO) && ((sq_q.size() == 0) || m_sq_ready);
            exp_cq_rdy = (cq_q.size() == 0) || m_cq_ready;
            chk("s_sq_ready", 128'(s_sq_ready), 128'(exp_sq_rdy));
            chk("s_cq_ready", 128'(s_cq_ready), 128'(exp_cq_rdy));
            chk("m_sq_valid", 128'(m_sq_valid), 128'(sq_q.size() != 0));
            chk("m_sq_data", 128'(m_sq_data), 128'(sq_last));
            chk("m_cq_valid", 128'(m_cq_valid), 128'(cq_q.size() != 0));
            chk("m_cq_data", 128'(m_cq_data), 128'(cq_last));
            chk("outstanding", 128'(outstanding), 128'(mdl_cnt));
            chk("stall_cycles", 128'(stall_cycles), 128'(mdl_stall));
            chk("err_underflow", 128'(err_underflow), 128'(mdl_err));

            inc    = s_sq_valid && exp_sq_rdy;
            dec    = s_cq_valid && exp_cq_rdy;
            sq_out = (sq_q.size() != 0) && m_sq_ready;
            cq_out = (cq_q.size() != 0) && m_cq_ready;

            @(posedge aclk);
            #1;
            if (areset) begin
                mdl_reset();
            end else begin
                if (s_sq_valid && (mdl_cnt >= MAXO) && (mdl_stall < 64'hFFFF_FFFF)) mdl_stall++;
                if (sq_out) void'(sq_q.pop_front());
                if (cq_out) void'(cq_q.pop_front());
                if (inc) begin sq_q.push_back(s_sq_data); sq_last = s_sq_data; end
                if (dec) begin cq_q.push_back(s_cq_data); cq_last = s_cq_data; end
                if (inc && !dec) mdl_cnt++;
                else if (dec && !inc) begin
                    if (mdl_cnt > 0) mdl_cnt--;
                    else mdl_err = 1'b1;
                end
                if (clr_err) begin
                    mdl_err   = 1'b0;
                    mdl_stall = 0;
                end
            end

            // Phases: fill credits, balanced traffic, heavy downstream back-pressure
            case ((c / 500) % 3)
                0:       begin cq_pct = 10; mr_pct = 90; end
                1:       begin cq_pct = 50; mr_pct = 60; end
                default: begin cq_pct = 30; mr_pct = 15; end
            endcase

            if (!s_sq_valid || inc) begin
                s_sq_valid = ($urandom_range(99, 0) < 75);
                s_sq_data  = rnd_sq();
            end
            if (!s_cq_valid || dec) begin
                s_cq_valid = ($urandom_range(99, 0) < cq_pct);
                s_cq_data  = $urandom();
            end
            m_sq_ready = ($urandom_range(99, 0) < mr_pct);
            m_cq_ready = ($urandom_range(99, 0) < 70);
            clr_err    = ($urandom_range(59, 0) == 0);
            areset     = ($urandom_range(249, 0) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
